lab7_1_rate_sched: RTL and testbench

//  Sequencer that schedules the divider's clock-select line on the 1 Hz tick clock.

---
 rtl/lab7_1_rate_sched.sv | 191 +++++++++++++++++++
 tb/tb_lab7_1_rate_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab7_1_rate_sched.sv
// lab7_1_rate_sched
// Sequencer that drives the divider's clock-select line. It runs on the 1 Hz tick clock.
// A run is LOOPS rounds. Each round is a slow phase of SLOW_SEC ticks (sqclk=0) followed
// by a fast phase of FAST_SEC ticks (sqclk=1).
// A BCD countdown of the ticks left in the current phase is exported for the 7-seg driver.
//
// Control inputs are levels sampled on the rising edge of clk_tmp1:
//   abort  - highest priority; any state returns to IDLE and the counters clear.
//   pause  - freezes state and counters, but only in SLOW/FAST.
//   start  - only looked at in IDLE.
// Every output is either a register or a pure decode of the state register. No input
// reaches an output combinationally, so sqclk can only move on a tick edge.
module lab7_1_rate_sched #(
  parameter int SLOW_SEC = 5,
  parameter int FAST_SEC = 3,
  parameter int LOOPS    = 4
) (
  input  logic       clk_tmp1,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic       sqclk,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] loop_left
);

  // The state encoding doubles as the phase output code.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SLOW = 2'b01,
    S_FAST = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Converts a 0..99 constant into {tens, ones} BCD. It is only used on parameters.
  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  localparam logic [7:0] SLOW_BCD = to_bcd(SLOW_SEC);
  localparam logic [7:0] FAST_BCD = to_bcd(FAST_SEC);
  localparam logic [3:0] LOOPS_W  = 4'(LOOPS);

  // Parameter legality: the BCD display holds two digits, and loop_left is 4 bits wide.
  if (SLOW_SEC < 1 || SLOW_SEC > 99) begin : g_bad_slow
    $error("lab7_1_rate_sched: SLOW_SEC must be in 1..99");
  end
  if (FAST_SEC < 1 || FAST_SEC > 99) begin : g_bad_fast
    $error("lab7_1_rate_sched: FAST_SEC must be in 1..99");
  end
  if (LOOPS < 1 || LOOPS > 15) begin : g_bad_loops
    $error("lab7_1_rate_sched: LOOPS must be in 1..15");
  end

  state_t     state_q, state_nx;
  logic [3:0] tens_q, tens_nx;
  logic [3:0] ones_q, ones_nx;
  logic [3:0] loop_q, loop_nx;

  // Decremented BCD value and the "last second" flag, shared by SLOW and FAST.
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;
  logic       sec_is_one;
  logic       last_loop;

  // BCD down-count by one: when ones is 0 it borrows from tens and wraps to 9.
  always_comb begin
    dec_tens   = tens_q;
    dec_ones   = ones_q;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
    end else begin
      dec_ones = ones_q - 4'd1;
    end
    sec_is_one = (tens_q == 4'd0) && (ones_q == 4'd1);
    last_loop  = (loop_q == 4'd1);
  end

  // State register; asynchronous reset lands in IDLE.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Countdown and round counters.
  // They are kept apart from the state register so that they can be bound to and checked
  // on their own.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      loop_q <= 4'd0;
    end else begin
      tens_q <= tens_nx;
      ones_q <= ones_nx;
      loop_q <= loop_nx;
    end
  end

  // Next-state and next-counter logic, in priority order: abort, then pause, then the
  // normal flow.
  always_comb begin
    state_nx = state_q;
    tens_nx  = tens_q;
    ones_nx  = ones_q;
    loop_nx  = loop_q;
    if (abort) begin
      state_nx = S_IDLE;
      tens_nx  = 4'd0;
      ones_nx  = 4'd0;
      loop_nx  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_nx = S_SLOW;
            tens_nx  = SLOW_BCD[7:4];
            ones_nx  = SLOW_BCD[3:0];
            loop_nx  = LOOPS_W;
          end
        end
        S_SLOW: begin
          if (!pause) begin
            if (sec_is_one) begin
              state_nx = S_FAST;
              tens_nx  = FAST_BCD[7:4];
              ones_nx  = FAST_BCD[3:0];
            end else begin
              tens_nx  = dec_tens;
              ones_nx  = dec_ones;
            end
          end
        end
        S_FAST: begin
          if (!pause) begin
            if (!sec_is_one) begin
              tens_nx  = dec_tens;
              ones_nx  = dec_ones;
            end else if (!last_loop) begin
              state_nx = S_SLOW;
              tens_nx  = SLOW_BCD[7:4];
              ones_nx  = SLOW_BCD[3:0];
              loop_nx  = loop_q - 4'd1;
            end else begin
              state_nx = S_DONE;
              tens_nx  = 4'd0;
              ones_nx  = 4'd0;
              loop_nx  = 4'd0;
            end
          end
        end
        S_DONE: begin
          // DONE is a single-cycle marker; start is not looked at until IDLE.
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
          tens_nx  = 4'd0;
          ones_nx  = 4'd0;
          loop_nx  = 4'd0;
        end
      endcase
    end
  end

  // Output decode. Each output depends only on the state register, never on an input.
  always_comb begin
    sqclk = (state_q == S_FAST);
    busy  = (state_q == S_SLOW) || (state_q == S_FAST);
    done  = (state_q == S_DONE);
    phase = state_q;
  end

  assign sec_tens  = tens_q;
  assign sec_ones  = ones_q;
  assign loop_left = loop_q;

endmodule

// File: tb/tb_lab7_1_rate_sched.sv
// Bench for lab7_1_rate_sched.
// The main instance uses the default parameters. A second instance with SLOW_SEC=12 and
// LOOPS=1 exercises the two-digit BCD countdown.
// Expected output vectors come from a small integer model of the sequencer. The model's
// predictions are queued as the stimulus is driven, and each one is popped once the DUT
// has clocked.
module tb_lab7_1_rate_sched;

  localparam int SLOW  = 5;
  localparam int FAST  = 3;
  localparam int LOOPS = 4;

  // Clock and reset
  logic clk_tmp1 = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_tmp1 = ~clk_tmp1;

  logic start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic sqclk, busy, done;
  logic [1:0] phase;
  logic [3:0] sec_tens, sec_ones, loop_left;

  logic start2 = 1'b0, pause2 = 1'b0, abort2 = 1'b0;
  logic sqclk2, busy2, done2;
  logic [1:0] phase2;
  logic [3:0] sec_tens2, sec_ones2, loop_left2;

  lab7_1_rate_sched dut (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
    .sqclk(sqclk), .busy(busy), .done(done), .phase(phase),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .loop_left(loop_left)
  );

  lab7_1_rate_sched #(.SLOW_SEC(12), .FAST_SEC(3), .LOOPS(1)) dut2 (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .start(start2), .pause(pause2), .abort(abort2),
    .sqclk(sqclk2), .busy(busy2), .done(done2), .phase(phase2),
    .sec_tens(sec_tens2), .sec_ones(sec_ones2), .loop_left(loop_left2)
  );

  // Scoreboard
  logic [16:0] exp_q[$];
  logic [9:0]  exp2_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 IDLE, 1 SLOW, 2 FAST, 3 DONE; sec kept as a plain integer
  int m_state = 0;
  int m_sec   = 0;
  int m_loop  = 0;

  function automatic logic [16:0] model_vec();
    logic [3:0] t, o, l;
    logic [1:0] ph;
    t  = 4'(m_sec / 10);
    o  = 4'(m_sec % 10);
    l  = 4'(m_loop);
    ph = 2'(m_state);
    return {m_state == 2, (m_state == 1) || (m_state == 2), m_state == 3, ph, t, o, l};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {sqclk, busy, done, phase, sec_tens, sec_ones, loop_left};
  endfunction

  task automatic model_reset();
    m_state = 0; m_sec = 0; m_loop = 0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic a);
    if (a) begin
      m_state = 0; m_sec = 0; m_loop = 0;
    end else begin
      case (m_state)
        0: if (s) begin m_state = 1; m_sec = SLOW; m_loop = LOOPS; end
        1: if (!p) begin
             if (m_sec > 1) m_sec = m_sec - 1;
             else begin m_state = 2; m_sec = FAST; end
           end
        2: if (!p) begin
             if (m_sec > 1) m_sec = m_sec - 1;
             else if (m_loop > 1) begin m_state = 1; m_sec = SLOW; m_loop = m_loop - 1; end
             else begin m_state = 3; m_sec = 0; m_loop = 0; end
           end
        default: m_state = 0;
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs, queue the model's prediction, clock, then settle
  task automatic drive(input logic s, input logic p, input logic a);
    start = s; pause = p; abort = a;
    model_step(s, p, a);
    exp_q.push_back(model_vec());
    @(posedge clk_tmp1);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] e, g;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    model_reset();
    #3;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL reset_async: got %h exp %h", g, e); end
    // start is high while reset is held: it must be ignored.
    start = 1'b1;
    @(posedge clk_tmp1); #1;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL reset_held: got %h exp %h", g, e); end
    start = 1'b0;
    @(negedge clk_tmp1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL idle_hold[%0d]: got %h exp %h", i, g, e); end
    end
  endtask

  task automatic test_full_run();
    logic [16:0] e, g;
    int busy_cnt, done_cnt, budget;
    busy_cnt = 0; done_cnt = 0; budget = 60;
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL run_start: got %h exp %h", g, e); end
    n_vec++;
    if ({phase, sec_tens, sec_ones, loop_left} !== {2'b01, 4'd0, 4'd5, 4'd4}) begin
      n_err++;
      $display("FAIL run_first: got %h exp %h", {phase, sec_tens, sec_ones, loop_left},
               {2'b01, 4'd0, 4'd5, 4'd4});
    end
    if (busy) busy_cnt++;
    while (m_state != 0 && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL run_cycle t=%0t: got %h exp %h", $time, g, e); end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      budget--;
    end
    n_vec++;
    if (budget == 0) begin n_err++; $display("FAIL run_timeout: got budget 0 exp >0"); end
    n_vec++;
    if (busy_cnt != 32) begin n_err++; $display("FAIL run_busy_count: got %0d exp 32", busy_cnt); end
    n_vec++;
    if (done_cnt != 1) begin n_err++; $display("FAIL run_done_count: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_bcd_borrow();
    logic [9:0] e, g;
    for (int i = 12; i >= 1; i--) exp2_q.push_back({2'b01, 4'(i / 10), 4'(i % 10)});
    for (int i = 3; i >= 1; i--) exp2_q.push_back({2'b10, 4'd0, 4'(i)});
    exp2_q.push_back({2'b11, 4'd0, 4'd0});
    exp2_q.push_back({2'b00, 4'd0, 4'd0});
    start2 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk_tmp1); #1;
      start2 = 1'b0;
      e = exp2_q.pop_front(); g = {phase2, sec_tens2, sec_ones2}; n_vec++;
      if (g !== e) begin n_err++; $display("FAIL bcd_cycle[%0d]: got %h exp %h", k, g, e); end
    end
  endtask

  task automatic test_pause();
    logic [16:0] e, g;
    int budget;
    budget = 40;
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL pause_start: got %h exp %h", g, e); end
    while (!(m_state == 2 && m_sec == 2) && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL pause_lead: got %h exp %h", g, e); end
      budget--;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL pause_hold[%0d]: got %h exp %h", i, g, e); end
      n_vec++;
      if ({sqclk, sec_tens, sec_ones, loop_left} !== {1'b1, 4'd0, 4'd2, 4'd4}) begin
        n_err++;
        $display("FAIL pause_frozen[%0d]: got %h exp %h", i,
                 {sqclk, sec_tens, sec_ones, loop_left}, {1'b1, 4'd0, 4'd2, 4'd4});
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL pause_resume: got %h exp %h", g, e); end
    n_vec++;
    if (sec_ones !== 4'd1) begin n_err++; $display("FAIL pause_resume_sec: got %0d exp 1", sec_ones); end
    budget = 40;
    while (m_state != 0 && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL pause_tail: got %h exp %h", g, e); end
      budget--;
    end
    n_vec++;
    if (budget == 0) begin n_err++; $display("FAIL pause_timeout: got budget 0 exp >0"); end
  endtask

  task automatic test_abort();
    logic [16:0] e, g;
    int budget;
    budget = 40;
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL abort_start: got %h exp %h", g, e); end
    while (!(m_state == 1 && m_loop == 3) && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL abort_lead: got %h exp %h", g, e); end
      budget--;
    end
    drive(1'b0, 1'b1, 1'b1);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL abort_edge: got %h exp %h", g, e); end
    n_vec++;
    if ({phase, busy, sec_tens, sec_ones, loop_left} !== 15'd0) begin
      n_err++;
      $display("FAIL abort_clear: got %h exp 0", {phase, busy, sec_tens, sec_ones, loop_left});
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL abort_after[%0d]: got %h exp %h", i, g, e); end
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done[%0d]: got %b exp 0", i, done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e, g;
    int budget;
    budget = 60;
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL b2b_start: got %h exp %h", g, e); end
    while (m_state != 3 && budget > 0) begin
      drive(1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL b2b_run: got %h exp %h", g, e); end
      budget--;
    end
    n_vec++;
    if (budget == 0) begin n_err++; $display("FAIL b2b_timeout: got budget 0 exp >0"); end
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL b2b_idle_gap: got %h exp %h", g, e); end
    n_vec++;
    if (phase !== 2'b00) begin n_err++; $display("FAIL b2b_gap_phase: got %b exp 00", phase); end
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL b2b_restart: got %h exp %h", g, e); end
    n_vec++;
    if ({phase, sec_ones, loop_left} !== {2'b01, 4'd5, 4'd4}) begin
      n_err++;
      $display("FAIL b2b_restart_val: got %h exp %h", {phase, sec_ones, loop_left}, {2'b01, 4'd5, 4'd4});
    end
    drive(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL b2b_abort: got %h exp %h", g, e); end
  endtask

  task automatic test_async_reset();
    logic [16:0] e, g;
    int budget;
    budget = 40;
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL arst_start: got %h exp %h", g, e); end
    while (!(m_state == 2 && m_sec == 2) && budget > 0) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL arst_lead: got %h exp %h", g, e); end
      budget--;
    end
    // Reset lands between edges; outputs must clear before any further clock edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_vec());
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL arst_immediate: got %h exp %h", g, e); end
    n_vec++;
    if (sqclk !== 1'b0) begin n_err++; $display("FAIL arst_sqclk: got %b exp 0", sqclk); end
    @(negedge clk_tmp1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = dut_vec(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL arst_idle[%0d]: got %h exp %h", i, g, e); end
    end
    drive(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL arst_restart: got %h exp %h", g, e); end
    drive(1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); g = dut_vec(); n_vec++;
    if (g !== e) begin n_err++; $display("FAIL arst_abort: got %h exp %h", g, e); end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_run();
    test_bcd_borrow();
    test_pause();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
